// File: rtl/sram_req_arbiter_if.sv
// One sram-like request/response port. The master drives the request fields;
// the slave answers with addr_ok/data_ok/rdata.
interface sram_req_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like memory port between the IF and EXE requesters, one transaction in flight.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats inst.
module sram_req_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    sram_req_arbiter_if.slave  inst,
    sram_req_arbiter_if.slave  data,
    sram_req_arbiter_if.master mem
);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam logic        OWN_INST = 1'b0;
    localparam logic        OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              grant_data_c;
    logic              in_req;
    logic              in_resp;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [STRB_W-1:0] sel_wstrb;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_ARB_RR_EN
    logic last_owner;

    // On a tie the port that did not win the previous grant goes first.
    assign grant_data_c = data.req & (~inst.req | (last_owner == OWN_INST));
`else
    assign grant_data_c = data.req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_INST;
`ifdef SRAM_ARB_RR_EN
            last_owner <= OWN_INST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inst.req | data.req) begin
                        owner <= grant_data_c;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem.addr_ok) begin
`ifdef SRAM_ARB_RR_EN
                        last_owner <= owner;
`endif
                        state <= RESP;
                    end
                end
                RESP: begin
                    // A data_ok outside RESP belongs to nothing we track and is dropped.
                    if (mem.data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields come straight from the owner; nothing is latched.
    always_comb begin
        if (owner == OWN_DATA) begin
            sel_wr    = data.wr;
            sel_size  = data.size;
            sel_wstrb = data.wstrb;
            sel_addr  = data.addr;
            sel_wdata = data.wdata;
        end else begin
            sel_wr    = inst.wr;
            sel_size  = inst.size;
            sel_wstrb = inst.wstrb;
            sel_addr  = inst.addr;
            sel_wdata = inst.wdata;
        end
    end

    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);

    assign mem.req   = in_req;
    assign mem.wr    = in_req & sel_wr;
    assign mem.size  = in_req ? sel_size  : '0;
    assign mem.wstrb = in_req ? sel_wstrb : '0;
    assign mem.addr  = in_req ? sel_addr  : '0;
    assign mem.wdata = in_req ? sel_wdata : '0;

    assign inst.addr_ok = in_req  & (owner == OWN_INST) & mem.addr_ok;
    assign data.addr_ok = in_req  & (owner == OWN_DATA) & mem.addr_ok;
    assign inst.data_ok = in_resp & (owner == OWN_INST) & mem.data_ok;
    assign data.data_ok = in_resp & (owner == OWN_DATA) & mem.data_ok;

    assign inst.rdata = mem.rdata;
    assign data.rdata = mem.rdata;
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (who owns the port, has it been accepted yet).
module tb_sram_req_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_if ();
    sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();
    sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (i_if),
        .data  (d_if),
        .mem   (m_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who = -1 none, 0 inst, 1 data; acc = request already accepted downstream.
    int who  = -1;
    bit acc  = 1'b0;
    bit last = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic i, input logic d);
        if (RR && i && d) return last ? 0 : 1;
        return d ? 1 : 0;
    endfunction

    // Called at a negedge with inputs already driven; checks, advances the model, returns at next negedge.
    task automatic step();
        logic        e_req, e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
        bit          drop_i, drop_d;
        #1;
        e_req   = (who >= 0) && !acc;
        e_wr    = 1'b0;
        e_size  = 2'd0;
        e_wstrb = 4'd0;
        e_addr  = 32'd0;
        e_wdata = 32'd0;
        if (e_req && who == 1) begin
            e_wr = d_if.wr; e_size = d_if.size; e_wstrb = d_if.wstrb; e_addr = d_if.addr; e_wdata = d_if.wdata;
        end else if (e_req) begin
            e_wr = i_if.wr; e_size = i_if.size; e_wstrb = i_if.wstrb; e_addr = i_if.addr; e_wdata = i_if.wdata;
        end
        check("mem_req",   m_if.req,   e_req);
        check("mem_wr",    m_if.wr,    e_wr);
        check("mem_size",  m_if.size,  e_size);
        check("mem_wstrb", m_if.wstrb, e_wstrb);
        check("mem_addr",  m_if.addr,  e_addr);
        check("mem_wdata", m_if.wdata, e_wdata);
        check("inst_addr_ok", i_if.addr_ok, e_req && who == 0 && m_if.addr_ok);
        check("data_addr_ok", d_if.addr_ok, e_req && who == 1 && m_if.addr_ok);
        check("inst_data_ok", i_if.data_ok, acc && who == 0 && m_if.data_ok);
        check("data_data_ok", d_if.data_ok, acc && who == 1 && m_if.data_ok);
        check("inst_rdata", i_if.rdata, m_if.rdata);
        check("data_rdata", d_if.rdata, m_if.rdata);

        drop_i = 1'b0;
        drop_d = 1'b0;
        if (reset) begin
            who = -1; acc = 1'b0; last = 1'b0;
        end else if (who < 0) begin
            if (i_if.req || d_if.req) who = pick(i_if.req, d_if.req);
        end else if (!acc) begin
            if (m_if.addr_ok) begin
                acc    = 1'b1;
                last   = (who == 1);
                drop_i = (who == 0);
                drop_d = (who == 1);
            end
        end else if (m_if.data_ok) begin
            who = -1; acc = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (drop_i) i_if.req = 1'b0;
        if (drop_d) d_if.req = 1'b0;
    endtask

    // One best-case transaction from IDLE: grant, accept, respond.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] rd);
        m_if.addr_ok = 1'b0;
        m_if.data_ok = 1'b0;
        step();
        m_if.addr_ok = 1'b1;
        #1 check("grant_addr", m_if.addr, exp_addr);
        step();
        m_if.addr_ok = 1'b0;
        m_if.data_ok = 1'b1;
        m_if.rdata   = rd;
        #1 check("resp_rdata", i_if.rdata, rd);
        step();
        m_if.data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_if.req = 0; i_if.wr = 0; i_if.size = 0; i_if.wstrb = 0; i_if.addr = 0; i_if.wdata = 0;
        d_if.req = 0; d_if.wr = 0; d_if.size = 0; d_if.wstrb = 0; d_if.addr = 0; d_if.wdata = 0;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 0;
        @(negedge clk);
        check("rst_mem_req", m_if.req, 1'b0);
        step();
        reset = 1'b0;

        // Single inst fetch
        i_if.size = 2'd2; i_if.addr = 32'h1c00_0000; i_if.req = 1'b1;
        serve(32'h1c00_0000, 32'h0280_0c0c);

        // Two ties: data wins the first; the second depends on the priority scheme
        i_if.req = 1'b1;
        d_if.wr = 1'b1; d_if.size = 2'd2; d_if.wstrb = 4'hf; d_if.addr = 32'h800; d_if.wdata = 32'hdead_beef;
        d_if.req = 1'b1;
        serve(32'h800, $urandom);
        d_if.req = 1'b1;
        serve(RR ? 32'h1c00_0000 : 32'h800, $urandom);
        serve(RR ? 32'h800 : 32'h1c00_0000, $urandom);

        // Stall in REQ with a spurious data_ok in the middle
        i_if.addr = 32'h1c00_0040; i_if.req = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            m_if.data_ok = (k == 2);
            #1;
            check("stall_req", m_if.req, 1'b1);
            check("stall_addr", m_if.addr, 32'h1c00_0040);
            check("spurious_data_ok", i_if.data_ok, 1'b0);
            step();
        end
        m_if.data_ok = 1'b0;
        m_if.addr_ok = 1'b1;
        step();
        m_if.addr_ok = 1'b0;
        m_if.data_ok = 1'b1;
        #1 check("late_data_ok", i_if.data_ok, 1'b1);
        step();
        m_if.data_ok = 1'b0;

        // Reset while waiting for the response; the late data_ok must be discarded
        i_if.req = 1'b1;
        step();
        m_if.addr_ok = 1'b1;
        step();
        m_if.addr_ok = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_if.data_ok = 1'b1;
        #1 check("post_rst_data_ok", i_if.data_ok, 1'b0);
        step();
        m_if.data_ok = 1'b0;
        #1 check("post_rst_idle", m_if.req, 1'b0);
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(299) == 0);
            if (reset) begin
                i_if.req = 1'b0;
                d_if.req = 1'b0;
            end else begin
                if (!i_if.req && $urandom_range(2) == 0) begin
                    i_if.wr = ($urandom_range(7) == 0); i_if.size = 2'($urandom_range(2));
                    i_if.wstrb = 4'($urandom); i_if.addr = $urandom; i_if.wdata = $urandom;
                    i_if.req = 1'b1;
                end
                if (!d_if.req && $urandom_range(2) == 0) begin
                    d_if.wr = 1'($urandom); d_if.size = 2'($urandom_range(2));
                    d_if.wstrb = 4'($urandom); d_if.addr = $urandom; d_if.wdata = $urandom;
                    d_if.req = 1'b1;
                end
            end
            m_if.addr_ok = (who >= 0 && !acc) ? ($urandom_range(2) == 0) : 1'b0;
            m_if.data_ok = (who >= 0 && acc) ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
            m_if.rdata   = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
